// File: rtl/add_share_pkg.sv
// Shared defaults, state encoding and round-robin pointer helper
// for the shared-adder arbiter.
package add_share_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int WIDTH_DEF = 32;

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   typedef enum logic {
      EMPTY = ST_EMPTY,
      FULL  = ST_FULL
   } state_e;

   function automatic int next_ptr(input int k, input int n);
      return (k + 1 >= n) ? 0 : k + 1;
   endfunction

endpackage

// File: rtl/add_share_arbiter_if.sv
// Requester and response bundle of the shared-adder arbiter.
// Carries o_rsp_ovf only when ADD_SHARE_OVF_EN is defined.
interface add_share_arbiter_if
   import add_share_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int ID_W  = $clog2(N_REQ)
) ();

   logic [N_REQ-1:0]       i_req_valid;
   logic [N_REQ*WIDTH-1:0] i_req_op1;
   logic [N_REQ*WIDTH-1:0] i_req_op2;
   logic [N_REQ-1:0]       o_req_ready;
   logic                   o_rsp_valid;
   logic [ID_W-1:0]        o_rsp_id;
   logic [WIDTH-1:0]       o_rsp_data;
   logic                   i_rsp_ready;
`ifdef ADD_SHARE_OVF_EN
   logic                   o_rsp_ovf;
`endif

   modport master (
      output i_req_valid, i_req_op1, i_req_op2, i_rsp_ready,
`ifdef ADD_SHARE_OVF_EN
      input  o_rsp_ovf,
`endif
      input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data
   );

   modport slave (
      input  i_req_valid, i_req_op1, i_req_op2, i_rsp_ready,
`ifdef ADD_SHARE_OVF_EN
      output o_rsp_ovf,
`endif
      output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data
   );

endinterface

// File: rtl/add_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or
// above ptr, wrapping modulo N.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W:0] j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = '0;
      for (int i = 0; i < N; i++) begin
         j = {1'b0, ptr} + (IDX_W+1)'(i);
         if (j >= (IDX_W+1)'(N)) j = j - (IDX_W+1)'(N);
         if (!any && req[j[IDX_W-1:0]]) begin
            any = 1'b1;
            gnt[j[IDX_W-1:0]] = 1'b1;
            idx = j[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/add_share_arbiter.sv
// One shared adder arbitrated round-robin across N_REQ requesters,
// with a registered tagged response. ADD_SHARE_OVF_EN adds o_rsp_ovf.
module add_share_arbiter
   import add_share_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input logic             i_clk,
   input logic             i_rst,
   add_share_arbiter_if.slave bus
);

   state_e           state;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  win_idx;
   logic [ID_W-1:0]  rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic [N_REQ-1:0] gnt;
   logic             any;
   logic             can_accept;
   logic             acc;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum;

   rr_pick #(.N(N_REQ), .IDX_W(ID_W)) u_pick (
      .req (bus.i_req_valid),
      .ptr (ptr),
      .gnt (gnt),
      .idx (win_idx),
      .any (any)
   );

   // Draining and reloading in the same cycle keeps throughput at one per cycle.
   assign can_accept = (state == EMPTY) || bus.i_rsp_ready;
   assign bus.o_req_ready = (can_accept && any && !i_rst) ? gnt : '0;
   assign acc = |(bus.i_req_valid & bus.o_req_ready);

   assign op_a = bus.i_req_op1[win_idx*WIDTH +: WIDTH];
   assign op_b = bus.i_req_op2[win_idx*WIDTH +: WIDTH];
   assign sum  = op_a + op_b;

   assign bus.o_rsp_valid = (state == FULL);
   assign bus.o_rsp_id    = rsp_id;
   assign bus.o_rsp_data  = rsp_data;

`ifdef ADD_SHARE_OVF_EN
   logic rsp_ovf;
   logic ovf_nxt;

   assign ovf_nxt = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                    (sum[WIDTH-1] != op_a[WIDTH-1]);
   assign bus.o_rsp_ovf = rsp_ovf;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)    rsp_ovf <= 1'b0;
      else if (acc) rsp_ovf <= ovf_nxt;
   end
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= EMPTY;
         ptr      <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
      end else begin
         if (acc) begin
            rsp_data <= sum;
            rsp_id   <= win_idx;
            ptr      <= ID_W'(next_ptr(int'(win_idx), N_REQ));
         end
         unique case (state)
            EMPTY: if (acc) state <= FULL;
            FULL:  if (bus.i_rsp_ready && !acc) state <= EMPTY;
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one 32-bit combinational adder between N_REQ requesters.
- Each requester uses a valid/ready handshake to present an operand pair.
- A round-robin arbiter grants one requester per cycle, registers the sum and tags it with the requester ID. The response port holds the result until downstream accepts it.
- Sits between ALU/address-generation clients and the single shared adder in the datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width.
- ID_W, $clog2(N_REQ), width of the requester ID.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_req_valid  input  N_REQ  per-requester request valid.
- i_req_op1  input  N_REQ*WIDTH  flattened first operands; requester k uses bits [k*WIDTH +: WIDTH].
- i_req_op2  input  N_REQ*WIDTH  flattened second operands, same packing.
- o_req_ready  output  N_REQ  one-hot grant/accept; at most one bit set.
- o_rsp_valid  output  1  response register holds a result.
- o_rsp_id  output  ID_W  requester index of the held result.
- o_rsp_data  output  WIDTH  held sum, modulo 2^WIDTH.
- i_rsp_ready  input  1  downstream accepts the response.

Behaviour:
- Reset (async, i_rst=1): o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, rr pointer=0, o_req_ready=0.
- State machine has two states, EMPTY and FULL, equal to the value of o_rsp_valid.
- can_accept = !o_rsp_valid || i_rsp_ready. A pass-through drain gives throughput of one per cycle.
- Grant selection (combinational):
  - Winner is the first k with i_req_valid[k]=1, searching from ptr upward and wrapping modulo N_REQ.
  - o_req_ready[k] = can_accept && winner==k && any valid.
- Accept: when i_req_valid[k] && o_req_ready[k], then next cycle:
  - o_rsp_data = op1_k + op2_k, truncated to WIDTH.
  - o_rsp_id = k.
  - o_rsp_valid = 1.
  - ptr = (k+1) mod N_REQ, wrapping from N_REQ-1 to 0.
- Latency: exactly 1 cycle from accept edge to o_rsp_valid.
- Drain without new accept: if i_rsp_ready && o_rsp_valid && no request is accepted, o_rsp_valid->0 next cycle. Data and ID keep their old value.
- Simultaneous drain and accept in FULL: the register reloads with the new result and o_rsp_valid stays 1. No bubble.
- FULL with i_rsp_ready=0:
  - All o_req_ready=0 and ptr holds.
  - o_rsp_data and o_rsp_id are stable until accepted.
- No requests valid: ptr holds and state is unchanged except for a drain.
- Requesters must keep valid and operands stable until ready. The block samples operands only on the accept edge.
- Reset mid-transaction discards the held result immediately (asynchronous). No response is issued for it.
- Operand changes while a requester is not granted have no effect.

Optional Feature:
- Macro ADD_SHARE_OVF_EN.
- Defined:
  - Adds output o_rsp_ovf (1 bit), registered alongside o_rsp_data.
  - o_rsp_ovf = signed two's-complement overflow of the sum: operand MSBs equal and sum MSB differs.
  - Resets to 0 and holds with the data.
- Undefined: port absent. No overflow logic.

Decomposition:
- Shared package add_share_pkg holds:
  - Default WIDTH/N_REQ constants.
  - State encoding localparams (ST_EMPTY=1'b0, ST_FULL=1'b1).
  - A function computing the next rr pointer.
- One natural sub-module is rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req vector and ptr. Outputs: one-hot grant and binary index.
  - Reusable by other arbiters in the CPU.
- The adder itself is a single instance inside the top block, fed by a mux on the winner index.

Test Plan:
- Reset, then one request: req0 valid, op1=5, op2=7 -> ready0=1 that cycle; next cycle rsp_valid=1, id=0, data=12.
- All four requesters valid continuously with i_rsp_ready=1 -> grants in order 0,1,2,3,0. One response per cycle with matching IDs.
- Backpressure: result held with i_rsp_ready=0 for 3 cycles -> all ready=0, data/id stable. Raising ready gives same-cycle accept of the next requester with no bubble.
- Wrap-around arithmetic: op1=32'hFFFF_FFFF, op2=32'h1 -> data=0. With ADD_SHARE_OVF_EN, op1=32'h7FFF_FFFF, op2=1 -> ovf=1.
- Pointer fairness: ptr=2 after granting 1; req0 and req3 valid -> req3 granted first, then req0.
- Async reset asserted while FULL mid-cycle -> rsp_valid drops without waiting for a clock edge, ptr=0, and no stale response after release.
